// File: rtl/mux_4_1_rr_arbiter_pkg.sv
// Shared types, constants and the round-robin pick function for mux_4_1_rr_arbiter.
package mux_4_1_rr_arbiter_pkg;

  localparam int unsigned NumReq = 4;
  localparam int unsigned SelW = 2;
  localparam logic [SelW-1:0] ResetLast = 2'd3;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  // First set bit scanning last+1, last+2, last+3, last (mod 4); returns last if req is zero.
  function automatic logic [SelW-1:0] rr_pick(input logic [NumReq-1:0] req,
                                              input logic [SelW-1:0] last);
    logic [SelW-1:0] idx;
    rr_pick = last;
    for (int k = NumReq; k >= 1; k--) begin
      idx = last + SelW'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux_4_1.sv
// Single-bit 4:1 multiplexer used as one slice of the shared selection datapath.
module mux_4_1 (
  output logic       z,
  input  logic [3:0] i,
  input  logic [1:0] s
);

  assign z = i[s];

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter sharing a W-bit 4:1 mux between 4 requesters, registered output.
// Optional grant hold limit is enabled by defining MUX_ARB_HOLD_LIMIT_EN.
module mux_4_1_rr_arbiter
  import mux_4_1_rr_arbiter_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [4*W-1:0]    din,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [W-1:0]      dout,
  output logic              dout_vld
);

  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("MAX_HOLD must be at least 2");
  end

  arb_state_e      state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] last_q, last_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            vld_q;
  logic            new_grant;
  logic [SelW-1:0] winner;
  logic [W-1:0]    mux_z;

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    new_grant = 1'b0;
    winner    = last_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          new_grant = 1'b1;
          winner    = rr_pick(req, last_q);
        end
      end
      StGrant: begin
        if (!req[sel_q]) begin
          if (|req) begin
            new_grant = 1'b1;
            winner    = rr_pick(req, last_q);
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end
`ifdef MUX_ARB_HOLD_LIMIT_EN
        // Forced hand-over excludes the current owner from the scan.
        else if (hold_cnt_q == HoldMax && |(req & ~gnt_q)) begin
          new_grant = 1'b1;
          winner    = rr_pick(req & ~gnt_q, last_q);
        end
`endif
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
    if (new_grant) begin
      state_d = StGrant;
      gnt_d   = 4'(1) << winner;
      sel_d   = winner;
      last_d  = winner;
    end
  end

`ifdef MUX_ARB_HOLD_LIMIT_EN
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (new_grant) begin
      hold_cnt_d = '0;
    end else if (state_q == StGrant && hold_cnt_q != HoldMax) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  for (genvar b = 0; b < W; b++) begin : g_mux
    logic [3:0] col;
    assign col = {din[3*W+b], din[2*W+b], din[W+b], din[b]};
    mux_4_1 u_mux (
      .z (mux_z[b]),
      .i (col),
      .s (sel_q)
    );
  end

  assign busy   = (state_q == StGrant);
  assign dout_d = busy ? mux_z : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= ResetLast;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      vld_q   <= busy;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign dout     = dout_q;
  assign dout_vld = vld_q;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Scoreboard bench for mux_4_1_rr_arbiter: stimulus pushes expected post-edge outputs,
// a monitor pops and compares them after every rising edge.
module tb_mux_4_1_rr_arbiter;

  localparam logic [7:0] D0 = 8'hA0;
  localparam logic [7:0] D1 = 8'hB1;
  localparam logic [7:0] D2 = 8'hC2;
  localparam logic [7:0] D3 = 8'hD3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] din = {D3, D2, D1, D0};
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        busy;
  logic [7:0]  dout;
  logic        dout_vld;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string      name;
    logic [3:0] gnt;
    logic       vld;
    logic [7:0] dout;
  } exp_t;

  exp_t sb[$];

  mux_4_1_rr_arbiter #(
    .W        (8),
    .MAX_HOLD (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din      (din),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    oh_idx = 2'd0;
    for (int k = 0; k < 4; k++) if (oh[k]) oh_idx = 2'(k);
  endfunction

  // Monitor: one expected entry per rising edge while the scoreboard holds entries.
  always @(posedge clk) begin : monitor
    exp_t e;
    logic ok;
    #2;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      ok = (gnt === e.gnt) && (busy === (|e.gnt)) && (dout_vld === e.vld) &&
           (dout === e.dout) && (!(|e.gnt) || sel === oh_idx(e.gnt));
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got gnt=%b sel=%0d busy=%b dout=%h vld=%b, want gnt=%b sel=%0d busy=%b dout=%h vld=%b",
                    e.name, gnt, sel, busy, dout, dout_vld,
                    e.gnt, oh_idx(e.gnt), |e.gnt, e.dout, e.vld);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, want);
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic ev,
                      input logic [7:0] ed, input string nm);
    exp_t e;
    @(negedge clk);
    req    = r;
    e.name = nm;
    e.gnt  = eg;
    e.vld  = ev;
    e.dout = ed;
    sb.push_back(e);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_vld", 32'(dout_vld), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Rotation through all four with pointer wrap back to 0.
    step(4'b1111, 4'b0001, 1'b0, 8'h00, "t1_first");
    step(4'b1111, 4'b0001, 1'b1, D0,    "t1_hold0");
    step(4'b1110, 4'b0010, 1'b1, D0,    "t1_to1");
    step(4'b1100, 4'b0100, 1'b1, D1,    "t1_to2");
    step(4'b1000, 4'b1000, 1'b1, D2,    "t1_to3");
    step(4'b1001, 4'b1000, 1'b1, D3,    "t1_hold3");
    step(4'b0001, 4'b0001, 1'b1, D3,    "t1_wrap0");
    step(4'b0000, 4'b0000, 1'b1, D0,    "t1_release");
    step(4'b0000, 4'b0000, 1'b0, 8'h00, "t1_idle");

    // Single requester 2, data path latency and last beat on release.
    step(4'b0100, 4'b0100, 1'b0, 8'h00, "t2_grant");
    step(4'b0100, 4'b0100, 1'b1, D2,    "t2_data1");
    step(4'b0100, 4'b0100, 1'b1, D2,    "t2_data2");
    step(4'b0000, 4'b0000, 1'b1, D2,    "t2_lastbeat");
    step(4'b0000, 4'b0000, 1'b0, 8'h00, "t2_idle");

    // Owner 1 drops while 3 rises, 2 waiting: 2 wins with no idle bubble.
    step(4'b0010, 4'b0010, 1'b0, 8'h00, "t3_grant1");
    step(4'b0110, 4'b0010, 1'b1, D1,    "t3_hold1");
    step(4'b1100, 4'b0100, 1'b1, D1,    "t3_to2");
    step(4'b1000, 4'b1000, 1'b1, D2,    "t3_to3");
    step(4'b1000, 4'b1000, 1'b1, D3,    "t3_hold3");

    // Asynchronous reset mid-grant.
    @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 32'h0);
    chk("async_sel", 32'(sel), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_dout", 32'(dout), 32'h0);
    chk("async_vld", 32'(dout_vld), 32'h0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    step(4'b1111, 4'b0001, 1'b0, 8'h00, "t4_first");
    step(4'b0000, 4'b0000, 1'b1, D0,    "t4_release");
    step(4'b0000, 4'b0000, 1'b0, 8'h00, "t4_idle");

    pulse_reset();
`ifdef MUX_ARB_HOLD_LIMIT_EN
    // Hold limit of 4 alternates 0 and 1, then a lone requester keeps the grant.
    for (int i = 0; i < 12; i++) begin
      logic [3:0] eg;
      logic [7:0] ed;
      eg = (((i / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
      ed = ((((i - 1) / 4) % 2) == 0) ? D0 : D1;
      if (i == 0) step(4'b0011, eg, 1'b0, 8'h00, "t5_first");
      else        step(4'b0011, eg, 1'b1, ed,    "t5_alt");
    end
    for (int i = 0; i < 10; i++) step(4'b0001, 4'b0001, 1'b1, D0, "t5_sole");
    step(4'b0000, 4'b0000, 1'b1, D0,    "t5_release");
    step(4'b0000, 4'b0000, 1'b0, 8'h00, "t5_idle");
`else
    // Without a hold limit requester 0 keeps the grant throughout.
    step(4'b0011, 4'b0001, 1'b0, 8'h00, "t6_first");
    for (int i = 0; i < 19; i++) step(4'b0011, 4'b0001, 1'b1, D0, "t6_hold");
    step(4'b0000, 4'b0000, 1'b1, D0,    "t6_release");
    step(4'b0000, 4'b0000, 1'b0, 8'h00, "t6_idle");
`endif

    repeat (3) @(posedge clk);
    #5;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
